// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter sharing one register-file write
// port between NREQ writeback requesters (valid/ready handshake), with a
// registered write port.
// Optional pending-write scoreboard enabled by `define REGFILE_ARB_SCOREBOARD_EN;
// without it qbusy1/qbusy2 are tied low and the scoreboard inputs are ignored.

module regfile_wb_arbiter #(
   parameter int NREQ = 2,
   parameter int AW   = 5,
   parameter int DW   = 32,
   parameter int NREG = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*AW-1:0] req_waddr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic             we,
   output logic [AW-1:0]    waddr,
   output logic [DW-1:0]    wdata,
   output logic [1:0]       gnt_id,
   input  logic             rsv_valid,
   input  logic [AW-1:0]    rsv_addr,
   input  logic [AW-1:0]    qaddr1,
   input  logic [AW-1:0]    qaddr2,
   output logic             qbusy1,
   output logic             qbusy2
);

   logic [1:0]    ptr_q, ptr_d;
   logic          we_q;
   logic [AW-1:0] waddr_q;
   logic [DW-1:0] wdata_q;
   logic [1:0]    gnt_q;

   logic [3:0]    valid_pad;
   logic [3:0]    gnt_oh;
   logic [1:0]    gnt_idx;
   logic          xfer;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_data;

   assign valid_pad = 4'(req_valid);

   // Round-robin scan starting at ptr_q; first valid requester wins.
   always_comb begin
      logic       found;
      logic [2:0] idx;
      gnt_oh  = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = {1'b0, ptr_q} + 3'(k);
         if (idx >= 3'(NREQ)) idx = idx - 3'(NREQ);
         if (!found && valid_pad[idx[1:0]]) begin
            found               = 1'b1;
            gnt_oh[idx[1:0]]    = 1'b1;
            gnt_idx             = idx[1:0];
         end
      end
   end

   assign req_ready = rst ? '0 : gnt_oh[NREQ-1:0];
   assign xfer      = |(req_valid & req_ready);

   // Select the granted requester's address and data.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_oh[i]) begin
            sel_addr = req_waddr[i*AW +: AW];
            sel_data = req_wdata[i*DW +: DW];
         end
      end
   end

   // Pointer moves past the requester that just transferred.
   always_comb begin
      ptr_d = ptr_q;
      if (xfer) ptr_d = (int'(gnt_idx) + 1 >= NREQ) ? 2'd0 : gnt_idx + 2'd1;
   end

   // Registered write port; address 0 updates addr/data but never writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q   <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         gnt_q   <= '0;
      end else begin
         ptr_q <= ptr_d;
         we_q  <= xfer && (sel_addr != '0);
         if (xfer) begin
            waddr_q <= sel_addr;
            wdata_q <= sel_data;
            gnt_q   <= gnt_idx;
         end
      end
   end

   assign we     = we_q;
   assign waddr  = waddr_q;
   assign wdata  = wdata_q;
   assign gnt_id = gnt_q;

`ifdef REGFILE_ARB_SCOREBOARD_EN
   logic [NREG-1:0] busy_q, busy_d;

   // Release on accepted write, then reserve, so a same-edge reserve wins.
   always_comb begin
      busy_d = busy_q;
      if (xfer && sel_addr != '0) busy_d[sel_addr] = 1'b0;
      if (rsv_valid && rsv_addr != '0) busy_d[rsv_addr] = 1'b1;
      busy_d[0] = 1'b0;
   end

   // Busy bit storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   assign qbusy1 = rst ? 1'b0 : busy_q[qaddr1];
   assign qbusy2 = rst ? 1'b0 : busy_q[qaddr2];
`else
   logic unused_sb;
   assign unused_sb = ^{rsv_valid, rsv_addr, qaddr1, qaddr2};
   assign qbusy1    = 1'b0;
   assign qbusy2    = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (NREQ=2). Scoreboard expectations
// follow REGFILE_ARB_SCOREBOARD_EN; the write-port expectations are the same
// in both builds.

module tb_regfile_wb_arbiter;

   localparam int NREQ = 2;
   localparam int AW   = 5;
   localparam int DW   = 32;
`ifdef REGFILE_ARB_SCOREBOARD_EN
   localparam logic SB = 1'b1;
`else
   localparam logic SB = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NREQ-1:0]    req_valid = '0;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*AW-1:0] req_waddr = '0;
   logic [NREQ*DW-1:0] req_wdata = '0;
   logic             we;
   logic [AW-1:0]    waddr;
   logic [DW-1:0]    wdata;
   logic [1:0]       gnt_id;
   logic             rsv_valid = 1'b0;
   logic [AW-1:0]    rsv_addr = '0;
   logic [AW-1:0]    qaddr1 = '0;
   logic [AW-1:0]    qaddr2 = '0;
   logic             qbusy1, qbusy2;

   int total = 0;
   int bad   = 0;

   regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .NREG(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_waddr(req_waddr), .req_wdata(req_wdata),
      .we(we), .waddr(waddr), .wdata(wdata), .gnt_id(gnt_id),
      .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
      .qaddr1(qaddr1), .qaddr2(qaddr2),
      .qbusy1(qbusy1), .qbusy2(qbusy2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_waddr[i*AW +: AW] = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic chk_port(input string tag, input logic e_we, input logic [AW-1:0] e_a,
                           input logic [DW-1:0] e_d, input logic [1:0] e_g);
      chk({tag, ".we"},    64'(we),     64'(e_we));
      chk({tag, ".waddr"}, 64'(waddr),  64'(e_a));
      chk({tag, ".wdata"}, 64'(wdata),  64'(e_d));
      chk({tag, ".gnt"},   64'(gnt_id), 64'(e_g));
   endtask

   initial begin
      logic [1:0] g;

      // Reset state with both requesters valid.
      req_valid = 2'b11;
      qaddr1 = 5'd7;
      #12;
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_qbusy", 64'({qbusy1, qbusy2}), 64'd0);
      chk_port("rst", 1'b0, '0, '0, 2'd0);
      req_valid = 2'b00;
      @(negedge clk);
      rst = 1'b0;

      // Single requester 0.
      set_req(0, 5'd3, 32'h1234);
      req_valid = 2'b01;
      #1 chk("single_ready", 64'(req_ready), 64'b01);
      @(negedge clk);
      chk_port("single", 1'b1, 5'd3, 32'h1234, 2'd0);
      req_valid = 2'b00;
      @(negedge clk);
      chk_port("single_idle", 1'b0, 5'd3, 32'h1234, 2'd0);

      // Contention: pointer is at 1 after req 0 was served.
      set_req(0, 5'd4, 32'hA0A0_0004);
      set_req(1, 5'd5, 32'hB0B0_0005);
      req_valid = 2'b11;
      g = 2'd1;
      for (int n = 0; n < 4; n++) begin
         #1 chk("cont_ready", 64'(req_ready), 64'(2'b01 << g));
         @(negedge clk);
         chk_port("cont", 1'b1, (g == 2'd0) ? 5'd4 : 5'd5,
                  (g == 2'd0) ? 32'hA0A0_0004 : 32'hB0B0_0005, g);
         g = g ^ 2'd1;
      end
      req_valid = 2'b00;
      @(negedge clk);
      chk("cont_idle_we", 64'(we), 64'd0);

      // Address 0 from requester 1: accepted, no write, pointer advances.
      set_req(1, 5'd0, 32'h55);
      req_valid = 2'b10;
      #1 chk("a0_ready", 64'(req_ready), 64'b10);
      @(negedge clk);
      chk_port("a0", 1'b0, 5'd0, 32'h55, 2'd1);
      req_valid = 2'b11;
      #1 chk("a0_ptr", 64'(req_ready), 64'b01);
      req_valid = 2'b00;
      @(negedge clk);

      // Scoreboard: reserve 7, address-0 reserve ignored.
      qaddr1 = 5'd7;
      qaddr2 = 5'd8;
      rsv_valid = 1'b1;
      rsv_addr = 5'd7;
      @(negedge clk);
      rsv_addr = 5'd0;
      @(negedge clk);
      rsv_valid = 1'b0;
      chk("sb_rsv_q1", 64'(qbusy1), 64'(SB));
      chk("sb_rsv_q2", 64'(qbusy2), 64'd0);
      qaddr2 = 5'd0;
      #1 chk("sb_a0_q2", 64'(qbusy2), 64'd0);

      // Write to 7 releases it.
      set_req(0, 5'd7, 32'h7777);
      req_valid = 2'b01;
      @(negedge clk);
      req_valid = 2'b00;
      chk("sb_rel_q1", 64'(qbusy1), 64'd0);
      chk_port("sb_rel", 1'b1, 5'd7, 32'h7777, 2'd0);

      // Reserve and write 7 on the same edge: reservation wins.
      rsv_valid = 1'b1;
      rsv_addr = 5'd7;
      req_valid = 2'b01;
      @(negedge clk);
      rsv_valid = 1'b0;
      req_valid = 2'b00;
      chk("sb_same_q1", 64'(qbusy1), 64'(SB));
      chk_port("sb_same", 1'b1, 5'd7, 32'h7777, 2'd0);

      // Async reset mid-cycle while we=1.
      set_req(0, 5'd9, 32'h99);
      req_valid = 2'b01;
      @(negedge clk);
      chk("pre_rst_we", 64'(we), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk_port("arst", 1'b0, '0, '0, 2'd0);
      chk("arst_ready", 64'(req_ready), 64'd0);
      chk("arst_qbusy", 64'(qbusy1), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      req_valid = 2'b11;
      #1 chk("post_rst_ready", 64'(req_ready), 64'b01);
      chk("post_rst_qbusy", 64'(qbusy1), 64'd0);
      @(negedge clk);
      chk_port("post_rst", 1'b1, 5'd9, 32'h99, 2'd0);
      req_valid = 2'b00;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
